// File: rtl/sdrd_deserializer_if.sv
// Word handshake between the SDRD deserializer (master) and the host-side consumer (slave).
interface sdrd_deserializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] word_data;
  logic             word_valid;
  logic             word_ready;

  modport master (output word_data, output word_valid, input word_ready);
  modport slave  (input word_data, input word_valid, output word_ready);
endinterface

// File: rtl/sdrd_deserializer.sv
// Assembles SDRD serial bits into WIDTH-bit words behind a one-entry valid/ready holding register.
// Define SDRD_PARITY_EN to add a trailing odd-parity bit per word and the sticky par_err output.
module sdrd_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sser_n,
  input  logic                 bit_stb,
  input  logic                 sdrd,
  input  logic                 frame_start,
  input  logic                 ovr_clr,
  sdrd_deserializer_if.master  word_if,
  output logic                 busy,
`ifdef SDRD_PARITY_EN
  output logic                 par_err,
`endif
  output logic                 overrun
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
`ifdef SDRD_PARITY_EN
    PAR   = 2'd2,
`endif
    DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  hold_q, hold_d;
  logic              valid_q, valid_d;
  logic              ovr_q, ovr_d;
`ifdef SDRD_PARITY_EN
  logic              parErr_q, parErr_d;
`endif

  logic inFrame;
  logic lastBit;
  logic dataStb;

  always_comb begin
    inFrame = (state_q == SHIFT);
`ifdef SDRD_PARITY_EN
    inFrame = inFrame || (state_q == PAR);
`endif
    lastBit = (cnt_q == CW'(WIDTH - 1));
    // A strobe carries data in SHIFT, or as the first bit of a frame restarted from PAR.
    dataStb = inFrame && !sser_n && bit_stb && (frame_start || (state_q == SHIFT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (frame_start && !sser_n) state_d = SHIFT;
      SHIFT: begin
        if (sser_n)                    state_d = IDLE;
        else if (frame_start)          state_d = SHIFT;
`ifdef SDRD_PARITY_EN
        else if (bit_stb && lastBit)   state_d = PAR;
`else
        else if (bit_stb && lastBit)   state_d = DONE;
`endif
      end
`ifdef SDRD_PARITY_EN
      PAR: begin
        if (sser_n)                    state_d = IDLE;
        else if (frame_start)          state_d = SHIFT;
        else if (bit_stb)              state_d = DONE;
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy               = inFrame;
    word_if.word_data  = hold_q;
    word_if.word_valid = valid_q;
    overrun            = ovr_q;
`ifdef SDRD_PARITY_EN
    par_err            = parErr_q;
`endif
  end

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if ((state_q == IDLE || inFrame) && frame_start && !sser_n) begin
      shift_d = '0;
      cnt_d   = '0;
    end
    if (dataStb) begin
      if (MSB_FIRST) shift_d = {shift_d[WIDTH-2:0], sdrd};
      else           shift_d = {sdrd, shift_d[WIDTH-1:1]};
      cnt_d = cnt_d + CW'(1);
    end
  end

  // Holding register: a refill in DONE may coincide with a drain; otherwise the new word is lost.
  always_comb begin
    hold_d  = hold_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (valid_q && word_if.word_ready) valid_d = 1'b0;
    if (ovr_clr) ovr_d = 1'b0;
    if (state_q == DONE) begin
      if (!valid_q || word_if.word_ready) begin
        hold_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

`ifdef SDRD_PARITY_EN
  always_comb begin
    parErr_d = parErr_q;
    if (ovr_clr) parErr_d = 1'b0;
    if (state_q == PAR && !sser_n && !frame_start && bit_stb && !(^{shift_q, sdrd}))
      parErr_d = 1'b1;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q  <= '0;
      cnt_q    <= '0;
      hold_q   <= '0;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
`ifdef SDRD_PARITY_EN
      parErr_q <= 1'b0;
`endif
    end else begin
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      valid_q  <= valid_d;
      ovr_q    <= ovr_d;
`ifdef SDRD_PARITY_EN
      parErr_q <= parErr_d;
`endif
    end
  end

endmodule

// File: tb/tb_sdrd_deserializer.sv
// Directed bench for sdrd_deserializer: an MSB-first and an LSB-first instance share one stimulus stream.
module tb_sdrd_deserializer;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sser_n = 1'b1;
  logic bit_stb = 1'b0;
  logic sdrd = 1'b0;
  logic frame_start = 1'b0;
  logic ovr_clr = 1'b0;
  logic ready = 1'b0;
  logic busyM, busyL, ovrM, ovrL;
`ifdef SDRD_PARITY_EN
  logic parM, parL;
`endif

  int checks = 0;
  int errors = 0;

  sdrd_deserializer_if #(.WIDTH(WIDTH)) busM ();
  sdrd_deserializer_if #(.WIDTH(WIDTH)) busL ();

  assign busM.word_ready = ready;
  assign busL.word_ready = ready;

  sdrd_deserializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dutM (
    .clk(clk), .rst_n(rst_n), .sser_n(sser_n), .bit_stb(bit_stb), .sdrd(sdrd),
    .frame_start(frame_start), .ovr_clr(ovr_clr), .word_if(busM), .busy(busyM),
`ifdef SDRD_PARITY_EN
    .par_err(parM),
`endif
    .overrun(ovrM)
  );

  sdrd_deserializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dutL (
    .clk(clk), .rst_n(rst_n), .sser_n(sser_n), .bit_stb(bit_stb), .sdrd(sdrd),
    .frame_start(frame_start), .ovr_clr(ovr_clr), .word_if(busL), .busy(busyL),
`ifdef SDRD_PARITY_EN
    .par_err(parL),
`endif
    .overrun(ovrL)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] stream;
    logic       parBit;
    logic [7:0] expMsb;
    logic [7:0] expLsb;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Sends one frame with the stream's bit 7 first; ends one #1 after the edge that samples the last bit.
  task automatic applyStimulus(input logic [7:0] stream, input logic parBit);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      sdrd = stream[i];
      bit_stb = 1'b1;
      tick();
    end
    sdrd = parBit;
`ifdef SDRD_PARITY_EN
    bit_stb = 1'b1;
    tick();
`endif
    bit_stb = 1'b0;
    sdrd = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'hB2, 1'b1, 8'hB2, 8'h4D};
    vecs[1] = '{8'h11, 1'b1, 8'h11, 8'h88};
    vecs[2] = '{8'h3C, 1'b1, 8'h3C, 8'h3C};
    vecs[3] = '{8'hFF, 1'b1, 8'hFF, 8'hFF};
    vecs[4] = '{8'h01, 1'b0, 8'h01, 8'h80};

    #1;
    checkOutput("rstData", busM.word_data, 8'h00);
    checkOutput("rstValid", busM.word_valid, 1'b0);
    checkOutput("rstBusy", busyM, 1'b0);
    checkOutput("rstOvr", ovrM, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    sser_n = 1'b0;
    ready = 1'b1;
    tick();

    // Basic words, both bit orders, with the consumer always ready.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].stream, vecs[i].parBit);
      checkOutput("latencyGap", busM.word_valid, 1'b0);
      checkOutput("busyInDone", busyM, 1'b0);
      tick();
      checkOutput("validRise", busM.word_valid, 1'b1);
      checkOutput("dataMsb", busM.word_data, vecs[i].expMsb);
      checkOutput("dataLsb", busL.word_data, vecs[i].expLsb);
      tick();
      checkOutput("validDrain", busM.word_valid, 1'b0);
    end

    // Restart mid-frame: three stray bits, then a fresh frame_start.
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    checkOutput("busyShift", busyM, 1'b1);
    for (int i = 0; i < 3; i++) begin
      sdrd = 1'b1;
      bit_stb = 1'b1;
      tick();
    end
    bit_stb = 1'b0;
    applyStimulus(vecs[0].stream, vecs[0].parBit);
    tick();
    checkOutput("restartMsb", busM.word_data, 8'hB2);
    checkOutput("restartLsb", busL.word_data, 8'h4D);
    tick();

    // Abort after five bits, then strobes while idle, then a complete frame.
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sdrd = 1'b1;
      bit_stb = 1'b1;
      tick();
    end
    bit_stb = 1'b0;
    sser_n = 1'b1;
    tick();
    checkOutput("abortBusy", busyM, 1'b0);
    sser_n = 1'b0;
    bit_stb = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    bit_stb = 1'b0;
    checkOutput("abortNoWord", busM.word_valid, 1'b0);
    checkOutput("abortNoOvr", ovrM, 1'b0);
    applyStimulus(vecs[2].stream, vecs[2].parBit);
    tick();
    checkOutput("afterAbort", busM.word_data, 8'h3C);
    checkOutput("afterAbortValid", busM.word_valid, 1'b1);
    tick();

    // Overrun: consumer stalled, second word is dropped.
    ready = 1'b0;
    applyStimulus(vecs[0].stream, vecs[0].parBit);
    tick();
    checkOutput("holdFirst", busM.word_data, 8'hB2);
    applyStimulus(vecs[1].stream, vecs[1].parBit);
    tick();
    checkOutput("ovrKeepData", busM.word_data, 8'hB2);
    checkOutput("ovrKeepValid", busM.word_valid, 1'b1);
    checkOutput("ovrSetM", ovrM, 1'b1);
    checkOutput("ovrSetL", ovrL, 1'b1);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    checkOutput("ovrClear", ovrM, 1'b0);

    // Simultaneous drain and refill while B2 is still held.
    applyStimulus(vecs[1].stream, vecs[1].parBit);
    checkOutput("refillPreValid", busM.word_valid, 1'b1);
    ready = 1'b1;
    tick();
    checkOutput("refillValid", busM.word_valid, 1'b1);
    checkOutput("refillMsb", busM.word_data, 8'h11);
    checkOutput("refillLsb", busL.word_data, 8'h88);
    checkOutput("refillNoOvr", ovrM, 1'b0);
    tick();
    checkOutput("refillDrain", busM.word_valid, 1'b0);

`ifdef SDRD_PARITY_EN
    checkOutput("parGood", parM, 1'b0);
    applyStimulus(8'hB2, 1'b0);
    tick();
    checkOutput("parBad", parM, 1'b1);
    checkOutput("parBadData", busM.word_data, 8'hB2);
    tick();
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    checkOutput("parClear", parM, 1'b0);
`endif

    // Async reset mid-frame with a word held and overrun set.
    ready = 1'b0;
    applyStimulus(vecs[0].stream, vecs[0].parBit);
    tick();
    applyStimulus(vecs[1].stream, vecs[1].parBit);
    tick();
    checkOutput("preRstOvr", ovrM, 1'b1);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sdrd = 1'b1;
      bit_stb = 1'b1;
      tick();
    end
    bit_stb = 1'b0;
    checkOutput("preRstBusy", busyM, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midRstData", busM.word_data, 8'h00);
    checkOutput("midRstValid", busM.word_valid, 1'b0);
    checkOutput("midRstBusy", busyM, 1'b0);
    checkOutput("midRstOvr", ovrM, 1'b0);
    checkOutput("midRstDataL", busL.word_data, 8'h00);
    tick();
    rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
